// File: rtl/core_mem_arbiter.sv
// Arbitrates the core instruction-fetch and LSU ports onto one single-port SRAM.
// LSU has fixed priority, a starvation counter guarantees fetch progress, and out-of-window accesses get error responses.
module core_mem_arbiter #(
   parameter int unsigned MEM_ADDR_WIDTH = 15,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned STARVE_LIMIT   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      instr_req_i,
   output logic                      instr_gnt_o,
   output logic                      instr_rvalid_o,
   input  logic [31:0]               instr_addr_i,
   output logic [31:0]               instr_rdata_o,
   output logic                      instr_err_o,
   input  logic                      lsu_req_i,
   output logic                      lsu_gnt_o,
   output logic                      lsu_rvalid_o,
   input  logic                      lsu_we_i,
   input  logic [3:0]                lsu_be_i,
   input  logic [31:0]               lsu_addr_i,
   input  logic [31:0]               lsu_wdata_i,
   output logic [31:0]               lsu_rdata_o,
   output logic                      lsu_err_o,
   output logic                      mem_req_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic                      mem_we_o,
   output logic [3:0]                mem_be_o,
   output logic [31:0]               mem_wdata_o,
   input  logic [31:0]               mem_rdata_i
);

   localparam int unsigned CNT_W    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [31:0] WIN_MASK = ~32'((64'd1 << MEM_ADDR_WIDTH) - 64'd1);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_owner_q, rsp_owner_d;
   logic             rsp_err_q, rsp_err_d;
   logic             instr_win, lsu_win;
   logic             instr_in_range, lsu_in_range;
   logic             rsp_live;

   assign instr_in_range = (instr_addr_i & WIN_MASK) == BASE_ADDR;
   assign lsu_in_range   = (lsu_addr_i & WIN_MASK) == BASE_ADDR;

   // Fixed LSU priority, overridden once the fetch port has been starved long enough.
   always_comb begin
      instr_win = 1'b0;
      lsu_win   = 1'b0;
      if (!rst) begin
         if (lsu_req_i && !(instr_req_i && (starve_cnt_q == CNT_MAX))) begin
            lsu_win = 1'b1;
         end else if (instr_req_i) begin
            instr_win = 1'b1;
         end
      end
   end

   assign instr_gnt_o = instr_win;
   assign lsu_gnt_o   = lsu_win;

   // SRAM request mux; out-of-window winners never reach the SRAM.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_wdata_o = 32'h0;
      if (lsu_win && lsu_in_range) begin
         mem_req_o   = 1'b1;
         mem_addr_o  = MEM_ADDR_WIDTH'(lsu_addr_i - BASE_ADDR);
         mem_we_o    = lsu_we_i;
         mem_be_o    = lsu_be_i;
         mem_wdata_o = lsu_wdata_i;
      end else if (instr_win && instr_in_range) begin
         mem_req_o   = 1'b1;
         mem_addr_o  = MEM_ADDR_WIDTH'(instr_addr_i - BASE_ADDR);
         mem_be_o    = 4'hF;
      end
   end

   // Next state: starvation count and the one-deep response pipeline.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      rsp_valid_d  = instr_win | lsu_win;
      rsp_owner_d  = rsp_owner_q;
      rsp_err_d    = rsp_err_q;
      if (!instr_req_i || instr_win) begin
         starve_cnt_d = '0;
      end else if (lsu_win && (starve_cnt_q != CNT_MAX)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
      if (lsu_win) begin
         rsp_owner_d = 1'b1;
         rsp_err_d   = !lsu_in_range;
      end else if (instr_win) begin
         rsp_owner_d = 1'b0;
         rsp_err_d   = !instr_in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_owner_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_owner_q  <= rsp_owner_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   // Responses are suppressed while reset is asserted so an in-flight one is dropped.
   assign rsp_live       = rsp_valid_q && !rst;
   assign instr_rvalid_o = rsp_live && !rsp_owner_q;
   assign lsu_rvalid_o   = rsp_live && rsp_owner_q;
   assign instr_err_o    = instr_rvalid_o && rsp_err_q;
   assign lsu_err_o      = lsu_rvalid_o && rsp_err_q;
   assign instr_rdata_o  = (instr_rvalid_o && !rsp_err_q) ? mem_rdata_i : 32'h0;
   assign lsu_rdata_o    = (lsu_rvalid_o && !rsp_err_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed vectors with literal expectations plus a
// per-cycle behavioural model (loss counting, pending-response scoreboard).
module tb_core_mem_arbiter;
   localparam int unsigned MAW   = 15;
   localparam int          LIMIT = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        lsu_req_i, lsu_gnt_o, lsu_rvalid_o, lsu_we_i, lsu_err_o;
   logic [3:0]  lsu_be_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [MAW-1:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o, mem_rdata_i;

   int tests = 0;
   int fails = 0;

   core_mem_arbiter #(.MEM_ADDR_WIDTH(MAW), .BASE_ADDR(BASE), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .lsu_req_i(lsu_req_i), .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
      .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i), .lsu_addr_i(lsu_addr_i),
      .lsu_wdata_i(lsu_wdata_i), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      return (a >= BASE) && ({32'h0, a} < ({32'h0, BASE} + (64'd1 << MAW)));
   endfunction

   // Model state: consecutive cycles fetch has lost, and the response owed next cycle.
   int lost = 0;
   int max_lost = 0;
   bit pend_v = 0, pend_lsu = 0, pend_err = 0;

   always @(negedge clk) begin : model_cmp
      bit iw, lw, ir, lr, ev, mreq;
      logic [31:0] eaddr, ewd;
      logic [3:0]  ebe;
      logic        ewe;
      ir = in_win(instr_addr_i);
      lr = in_win(lsu_addr_i);
      iw = !rst && instr_req_i && (!lsu_req_i || lost == LIMIT);
      lw = !rst && lsu_req_i && !iw;
      check("m_instr_gnt", 32'(instr_gnt_o), 32'(iw));
      check("m_lsu_gnt", 32'(lsu_gnt_o), 32'(lw));
      mreq = 0; eaddr = 0; ewe = 0; ebe = 0; ewd = 0;
      if (lw && lr) begin
         mreq = 1; eaddr = lsu_addr_i - BASE; ewe = lsu_we_i; ebe = lsu_be_i; ewd = lsu_wdata_i;
      end else if (iw && ir) begin
         mreq = 1; eaddr = instr_addr_i - BASE; ebe = 4'hF;
      end
      check("m_mem_req", 32'(mem_req_o), 32'(mreq));
      check("m_mem_addr", 32'(mem_addr_o), eaddr % (32'd1 << MAW));
      check("m_mem_we", 32'(mem_we_o), 32'(ewe));
      check("m_mem_be", 32'(mem_be_o), 32'(ebe));
      if (!(iw && mreq)) check("m_mem_wdata", mem_wdata_o, ewd);
      ev = !rst && pend_v;
      check("m_instr_rvalid", 32'(instr_rvalid_o), 32'(ev && !pend_lsu));
      check("m_lsu_rvalid", 32'(lsu_rvalid_o), 32'(ev && pend_lsu));
      check("m_instr_err", 32'(instr_err_o), 32'(ev && !pend_lsu && pend_err));
      check("m_lsu_err", 32'(lsu_err_o), 32'(ev && pend_lsu && pend_err));
      check("m_instr_rdata", instr_rdata_o, (ev && !pend_lsu && !pend_err) ? mem_rdata_i : 32'h0);
      check("m_lsu_rdata", lsu_rdata_o, (ev && pend_lsu && !pend_err) ? mem_rdata_i : 32'h0);
      if (rst) begin
         lost = 0; pend_v = 0;
      end else begin
         if (!instr_req_i || iw) lost = 0;
         else if (lw && lost < LIMIT) lost++;
         if (lost > max_lost) max_lost = lost;
         pend_v = iw || lw;
         if (lw) begin pend_lsu = 1; pend_err = !lr; end
         else if (iw) begin pend_lsu = 0; pend_err = !ir; end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      instr_req_i = 0; lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = 0;
      instr_addr_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 3))
         0: a = {17'h0, 15'($urandom) & 15'h7FFC};
         1: a = 32'h0000_7FFC;
         2: a = 32'h0000_8000;
         default: a = $urandom;
      endcase
      return a;
   endfunction

   initial begin
      bit got_i, got_l;
      rst = 1; mem_rdata_i = 0; idle();
      step(); step();
      check("rst_gnt", 32'({instr_gnt_o, lsu_gnt_o}), 32'h0);
      check("rst_rvalid", 32'({instr_rvalid_o, lsu_rvalid_o}), 32'h0);
      check("rst_mem", 32'({mem_req_o, mem_we_o, mem_be_o}), 32'h0);

      // Single fetch
      rst = 0; instr_req_i = 1; instr_addr_i = 32'h100;
      #1;
      check("fetch_gnt", 32'(instr_gnt_o), 32'h1);
      check("fetch_mem_addr", 32'(mem_addr_o), 32'h100);
      check("fetch_mem_be", 32'({mem_we_o, mem_be_o}), 32'h0F);
      step(); idle(); mem_rdata_i = 32'hCAFE_0001;
      #1;
      check("fetch_rvalid", 32'(instr_rvalid_o), 32'h1);
      check("fetch_rdata", instr_rdata_o, 32'hCAFE_0001);
      check("fetch_err", 32'(instr_err_o), 32'h0);

      // LSU write
      step(); lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'b0011; lsu_addr_i = 32'h40; lsu_wdata_i = 32'h1234_5678;
      #1;
      check("wr_gnt", 32'(lsu_gnt_o), 32'h1);
      check("wr_mem", 32'({mem_req_o, mem_we_o, mem_be_o}), 32'h33);
      check("wr_wdata", mem_wdata_o, 32'h1234_5678);
      step(); idle();
      #1;
      check("wr_rvalid", 32'(lsu_rvalid_o), 32'h1);

      // Starvation: fetch wins every fifth cycle
      for (int k = 0; k < 15; k++) begin
         step();
         instr_req_i = 1; instr_addr_i = 32'h200; lsu_req_i = 1; lsu_addr_i = 32'h300;
         mem_rdata_i = 32'h5000_0000 + 32'(k);
         #1;
         check("starve_igr", 32'(instr_gnt_o), 32'((k % 5) == 4));
      end
      check("starve_max", 32'(max_lost), 32'(LIMIT));
      step(); idle();

      // Out-of-range LSU read
      step(); lsu_req_i = 1; lsu_addr_i = 32'h2000_0000;
      #1;
      check("oor_gnt", 32'(lsu_gnt_o), 32'h1);
      check("oor_mem_req", 32'(mem_req_o), 32'h0);
      step(); idle(); mem_rdata_i = 32'hDEAD_BEEF;
      #1;
      check("oor_rsp", 32'({lsu_rvalid_o, lsu_err_o}), 32'h3);
      check("oor_rdata", lsu_rdata_o, 32'h0);

      // Reset mid-operation with both requests held; fetch must again wait four cycles
      step(); instr_req_i = 1; lsu_req_i = 1; instr_addr_i = 32'h10; lsu_addr_i = 32'h20;
      step();
      step(); rst = 1;
      #1;
      check("mrst_rvalid", 32'({instr_rvalid_o, lsu_rvalid_o}), 32'h0);
      check("mrst_gnt", 32'({instr_gnt_o, lsu_gnt_o, mem_req_o}), 32'h0);
      for (int k = 0; k < 5; k++) begin
         step(); rst = 0;
         #1;
         if (k == 0) check("post_rst_rvalid", 32'({instr_rvalid_o, lsu_rvalid_o}), 32'h0);
         check("post_rst_igr", 32'(instr_gnt_o), 32'(k == 4));
      end
      step(); idle();

      // Back-to-back alternation, including the window's last word
      step(); instr_req_i = 1; instr_addr_i = 32'h7FFC;
      step(); idle(); lsu_req_i = 1; lsu_addr_i = 32'h200; mem_rdata_i = 32'hA1;
      #1;
      check("alt1_irv", 32'({instr_rvalid_o, lsu_gnt_o}), 32'h3);
      check("alt1_rdata", instr_rdata_o, 32'hA1);
      step(); idle(); instr_req_i = 1; instr_addr_i = 32'h8000; mem_rdata_i = 32'hA2;
      #1;
      check("alt2_lrv", 32'({lsu_rvalid_o, instr_rvalid_o, instr_gnt_o, mem_req_o}), 32'hA);
      check("alt2_rdata", lsu_rdata_o, 32'hA2);
      step(); idle(); mem_rdata_i = 32'hA3;
      #1;
      check("alt3_ierr", 32'({instr_rvalid_o, instr_err_o}), 32'h3);
      check("alt3_rdata", instr_rdata_o, 32'h0);

      // Mixed traffic checked by the model; a losing requester holds its request
      got_i = 1; got_l = 1;
      for (int k = 0; k < 60; k++) begin
         step();
         if (!(instr_req_i && !got_i)) begin
            instr_req_i = 1'($urandom_range(0, 1)); instr_addr_i = rand_addr();
         end
         if (!(lsu_req_i && !got_l)) begin
            lsu_req_i = 1'($urandom_range(0, 1)); lsu_addr_i = rand_addr();
            lsu_we_i = 1'($urandom); lsu_be_i = 4'($urandom); lsu_wdata_i = $urandom;
         end
         mem_rdata_i = $urandom;
         #1;
         got_i = instr_gnt_o; got_l = lsu_gnt_o;
      end
      step(); idle();
      step(); step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

- Shares one single-port SRAM between the core instruction-fetch port and the core LSU port, both using the core req/gnt/rvalid protocol.
- LSU has fixed priority. A starvation counter forces an instruction grant after a bounded number of lost cycles.
- Requests outside the memory window are granted and answered with an error response; they are never forwarded to the SRAM.
- Sits between the core and a local SRAM as the low-latency alternative to the AXI interconnect path.

## Interface
- MEM_ADDR_WIDTH, 15: SRAM byte-address width. Window size is 2**MEM_ADDR_WIDTH bytes.
- BASE_ADDR, 32'h0000_0000: window base. Must be aligned to the window size.
- STARVE_LIMIT, 4: maximum consecutive cycles the instruction port may lose arbitration. Must be ≥1.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch grant (combinational)
- instr_rvalid_o  out  1  fetch response valid
- instr_addr_i  in  32  fetch byte address
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch response is an error (qualified by rvalid)
- lsu_req_i  in  1  LSU request
- lsu_gnt_o  out  1  LSU grant (combinational)
- lsu_rvalid_o  out  1  LSU response valid (reads and writes)
- lsu_we_i  in  1  write enable
- lsu_be_i  in  4  byte enables
- lsu_addr_i  in  32  LSU byte address
- lsu_wdata_i  in  32  write data
- lsu_rdata_o  out  32  LSU read data
- lsu_err_o  out  1  LSU response is an error (qualified by rvalid)
- mem_req_o  out  1  SRAM access strobe
- mem_addr_o  out  MEM_ADDR_WIDTH  SRAM byte address = addr − BASE_ADDR, truncated
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid one cycle after mem_req_o

## Operation
- **Arbitration, each cycle:** at most one grant.
  - Only one port requesting: that port is granted.
  - Both requesting: LSU is granted, unless starve_cnt == STARVE_LIMIT, in which case instruction is granted.
- **Starvation counter:** starve_cnt, width $clog2(STARVE_LIMIT+1), reset 0.
  - Increments when instr_req_i=1 and lsu_gnt_o=1.
  - Clears when instr_gnt_o=1 or instr_req_i=0.
  - Saturates at STARVE_LIMIT.
- **In-range check:** (addr & ~(2**MEM_ADDR_WIDTH−1)) == BASE_ADDR.
- **Forwarding:**
  - Granted in-range request: mem_req_o=1; address, we, be and wdata are muxed from the winner.
  - Instruction accesses drive we=0 and be=4'hF.
  - Granted out-of-range request: mem_req_o=0; the access is recorded as an error.
- **Response register:** rsp_valid, rsp_owner (0=instr, 1=lsu), rsp_err. Loaded on every grant; rsp_valid cleared when there is no grant.
  - Response cycle: owner's rvalid=1 and err=rsp_err.
  - rdata = mem_rdata_i when rsp_err=0; otherwise 32'h0.
  - rdata of the non-owner and of any idle port = 32'h0.
- **Idle outputs:** when mem_req_o=0, mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are all 0.

## Timing
- **Grant:** same cycle as req (combinational from req, address and starve_cnt).
- **Response latency:** rvalid exactly 1 cycle after gnt for reads, writes and errors.
- **Throughput:** one access per cycle, with back-to-back grants to the same or alternating ports.
- **Ordering:** no outstanding limit beyond one in-flight response. A new grant in the response cycle is legal because the pipeline is one deep.
- **Reset values:** all outputs 0. starve_cnt=0. rsp_valid=0.
- **Reset mid-operation:** the in-flight response is dropped; no rvalid is issued after rst.
- **Requester rules:**
  - The requester holds req and its request fields stable until gnt.
  - The arbiter never grants without req.
- **Error and starvation interaction:** an out-of-range LSU request still wins arbitration and still advances starve_cnt.

## Test plan
- **Single fetch:** instr_req at 0x100, mem_rdata_i=32'hCAFE_0001 in the next cycle → same-cycle gnt; mem_addr_o=0x100; instr_rvalid_o=1 with rdata 32'hCAFE_0001 one cycle later; err=0.
- **LSU write:** we=1, be=4'b0011, addr 0x40, wdata 32'h1234_5678 → mem_we_o=1 and mem_be_o=4'b0011 in the gnt cycle; lsu_rvalid_o=1 one cycle later.
- **Starvation, STARVE_LIMIT=4:** both ports request continuously → LSU granted 4 cycles, instr on the 5th, then LSU 4 cycles, and so on. starve_cnt never exceeds 4.
- **Out-of-range:** LSU addr 0x2000_0000 → gnt=1, mem_req_o=0; next cycle lsu_rvalid_o=1, lsu_err_o=1, rdata=0.
- **Reset mid-operation:** rst asserted in the cycle after a grant → no rvalid; all outputs 0; starve_cnt=0.
- **Back-to-back alternation:** instr, then lsu, then instr in consecutive cycles → each rvalid routed to the correct port with no bubbles.
